// File: rtl/exec_stage_md.sv
// Execute stage: forwarding muxes, ALU, branch resolution, single-cycle multiply and
// a radix-2 restoring divider, with a valid/ready result register toward MEM.
module exec_stage_md #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rrd1,
    input  logic [XLEN-1:0] rrd2,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      fwd_sel1,
    input  logic [1:0]      fwd_sel2,
    input  logic [XLEN-1:0] m_regwd,
    input  logic [XLEN-1:0] w_regwd,
    input  logic [1:0]      alu_srca,
    input  logic            alu_srcb,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      bj_op,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic [RA_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [RA_W-1:0] rd,
    output logic            b_taken
);
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_rem_q, is_rem_d;
    logic [RA_W-1:0] div_rd_q, div_rd_d;

    logic [XLEN-1:0] op1, op2, srca, srcb, alu_res, mul_res, div_quick, fast_res;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic            cond, accept;

    always_comb begin
        case (fwd_sel1)
            2'b01:   op1 = m_regwd;
            2'b10:   op1 = w_regwd;
            default: op1 = rrd1;
        endcase
        case (fwd_sel2)
            2'b01:   op2 = m_regwd;
            2'b10:   op2 = w_regwd;
            default: op2 = rrd2;
        endcase
        case (alu_srca)
            2'b00:   srca = op1;
            2'b10:   srca = pc;
            default: srca = '0;
        endcase
        srcb = alu_srcb ? imm : op2;
    end

    always_comb begin
        case (alu_op)
            4'd0:    alu_res = srca + srcb;
            4'd1:    alu_res = srca - srcb;
            4'd2:    alu_res = srca << srcb[ShW-1:0];
            4'd3:    alu_res = {{(XLEN - 1){1'b0}}, $signed(srca) < $signed(srcb)};
            4'd4:    alu_res = {{(XLEN - 1){1'b0}}, srca < srcb};
            4'd5:    alu_res = srca ^ srcb;
            4'd6:    alu_res = srca >> srcb[ShW-1:0];
            4'd7:    alu_res = $unsigned($signed(srca) >>> srcb[ShW-1:0]);
            4'd8:    alu_res = srca | srcb;
            4'd9:    alu_res = srca & srcb;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (bj_op)
            3'd0:    cond = 1'b0;
            3'd1:    cond = 1'b1;
            3'd2:    cond = srca == srcb;
            3'd3:    cond = srca != srcb;
            3'd4:    cond = $signed(srca) < $signed(srcb);
            3'd5:    cond = $signed(srca) >= $signed(srcb);
            3'd6:    cond = srca < srcb;
            default: cond = srca >= srcb;
        endcase
    end

    // One 2*XLEN multiplier; operand extension selects the signedness of each side.
    always_comb begin
        mul_a   = (md_op[1:0] != 2'b11) ? {{XLEN{srca[XLEN-1]}}, srca} : {{XLEN{1'b0}}, srca};
        mul_b   = !md_op[1] ? {{XLEN{srcb[XLEN-1]}}, srcb} : {{XLEN{1'b0}}, srcb};
        prod    = mul_a * mul_b;
        mul_res = (md_op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic            div_signed, div_is_rem, a_neg, b_neg, div_zero, div_ovf, div_long;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        div_signed = !md_op[0];
        div_is_rem = md_op[1];
        a_neg      = div_signed && srca[XLEN-1];
        b_neg      = div_signed && srcb[XLEN-1];
        a_mag      = a_neg ? -srca : srca;
        b_mag      = b_neg ? -srcb : srcb;
        div_zero   = srcb == '0;
        div_ovf    = div_signed && (srca == MinNeg) && (srcb == '1);
        div_long   = md_en && md_op[2] && !div_zero && !div_ovf;
        if (div_zero) begin
            div_quick = div_is_rem ? srca : '1;
        end else begin
            div_quick = div_is_rem ? '0 : srca;
        end
        if (!md_en) begin
            fast_res = alu_res;
        end else begin
            fast_res = md_op[2] ? div_quick : mul_res;
        end
    end

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    logic [XLEN:0]   r_sh, diff;
    logic [XLEN-1:0] step_rem, step_quo, div_res;

    always_comb begin
        r_sh     = {rem_q, quo_q[XLEN-1]};
        diff     = r_sh - {1'b0, dvs_q};
        step_rem = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], !diff[XLEN]};
        if (is_rem_q) begin
            div_res = r_neg_q ? -step_rem : step_rem;
        end else begin
            div_res = q_neg_q ? -step_quo : step_quo;
        end
    end

    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign b_taken  = accept && cond;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        is_rem_d    = is_rem_q;
        div_rd_d    = div_rd_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (accept && div_long) begin
                    state_d  = StBusy;
                    rem_d    = '0;
                    quo_d    = a_mag;
                    dvs_d    = b_mag;
                    cnt_d    = '0;
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    is_rem_d = div_is_rem;
                    div_rd_d = rd_in;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = fast_res;
                    rd_d        = rd_in;
                end
            end
            StBusy: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    result_d    = div_res;
                    rd_d        = div_rd_q;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            is_rem_q    <= 1'b0;
            div_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            is_rem_q    <= is_rem_d;
            div_rd_q    <= div_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd        = rd_q;

endmodule

// File: tb/tb_exec_stage_md.sv
// Randomized and directed checks of exec_stage_md against an arithmetic reference model.
module tb_exec_stage_md;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    typedef struct {
        logic [1:0]  fs1, fs2, sa;
        logic        sb;
        logic [3:0]  aop;
        logic [2:0]  bop;
        logic        md;
        logic [2:0]  mop;
        logic [31:0] pc, r1, r2, imm, mw, ww;
        logic [4:0]  rd;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, alu_srcb, md_en, out_valid, out_ready, b_taken;
    logic [31:0] pc, rrd1, rrd2, imm, m_regwd, w_regwd, result;
    logic [1:0]  fwd_sel1, fwd_sel2, alu_srca;
    logic [3:0]  alu_op;
    logic [2:0]  bj_op, md_op;
    logic [4:0]  rd_in, rd;

    int n_checks = 0;
    int n_errors = 0;

    exec_stage_md #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .rrd1(rrd1), .rrd2(rrd2), .imm(imm), .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2), .m_regwd(m_regwd), .w_regwd(w_regwd), .alu_srca(alu_srca),
        .alu_srcb(alu_srcb), .alu_op(alu_op), .bj_op(bj_op), .md_en(md_en), .md_op(md_op),
        .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .rd(rd), .b_taken(b_taken)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic op_t blank_op();
        op_t o;
        o.fs1 = 2'd0; o.fs2 = 2'd0; o.sa = 2'd0; o.sb = 1'b0; o.aop = 4'd0; o.bop = 3'd0;
        o.md = 1'b0; o.mop = 3'd0; o.pc = 32'd0; o.r1 = 32'd0; o.r2 = 32'd0; o.imm = 32'd0;
        o.mw = 32'd0; o.ww = 32'd0; o.rd = 5'd0;
        return o;
    endfunction

    function automatic logic [31:0] model_srca(input op_t o);
        logic [31:0] v;
        v = (o.fs1 == 2'd1) ? o.mw : (o.fs1 == 2'd2) ? o.ww : o.r1;
        if (o.sa == 2'd0) return v;
        if (o.sa == 2'd2) return o.pc;
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_srcb(input op_t o);
        if (o.sb) return o.imm;
        return (o.fs2 == 2'd1) ? o.mw : (o.fs2 == 2'd2) ? o.ww : o.r2;
    endfunction

    function automatic logic model_taken(input op_t o);
        int sa, sb;
        logic [31:0] a, b;
        a = model_srca(o); b = model_srcb(o);
        sa = int'(a); sb = int'(b);
        case (o.bop)
            3'd1: return 1'b1;
            3'd2: return a == b;
            3'd3: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_ovf(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic int model_latency(input op_t o);
        logic [31:0] a, b;
        a = model_srca(o); b = model_srcb(o);
        if (o.md && o.mop[2] && b != 0 && !(!o.mop[0] && is_ovf(a, b))) return 33;
        return 1;
    endfunction

    function automatic logic [31:0] model_result(input op_t o);
        logic [31:0] a, b;
        logic [63:0] up;
        longint sa, sb, ua, ub, p, d, q;
        int ia, ib, sh;
        a = model_srca(o); b = model_srcb(o);
        sa = longint'(int'(a)); sb = longint'(int'(b));
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        ia = int'(a); ib = int'(b);
        sh = int'(b[4:0]);
        d  = longint'(1) << sh;
        if (!o.md) begin
            case (o.aop)
                4'd0: return a + b;
                4'd1: return a - b;
                4'd2: begin p = ua * d; return p[31:0]; end
                4'd3: return (ia < ib) ? 32'd1 : 32'd0;
                4'd4: return (a < b) ? 32'd1 : 32'd0;
                4'd5: return a ^ b;
                4'd6: begin p = ua / d; return p[31:0]; end
                4'd7: begin
                    q = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
                    return q[31:0];
                end
                4'd8: return a | b;
                4'd9: return a & b;
                default: return 32'd0;
            endcase
        end
        case (o.mop)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (is_ovf(a, b)) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (is_ovf(a, b)) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic drive_op(input op_t o);
        fwd_sel1 = o.fs1; fwd_sel2 = o.fs2; alu_srca = o.sa; alu_srcb = o.sb;
        alu_op = o.aop; bj_op = o.bop; md_en = o.md; md_op = o.mop; pc = o.pc;
        rrd1 = o.r1; rrd2 = o.r2; imm = o.imm; m_regwd = o.mw; w_regwd = o.ww; rd_in = o.rd;
    endtask

    // Issue one op from idle, wait for its result, optionally stall the consumer, then drain.
    task automatic run_op(input op_t o, input int hold, output logic bt, output int lat);
        logic [31:0] exp_r;
        int exp_lat, busy;
        exp_r = model_result(o);
        exp_lat = model_latency(o);
        @(negedge clk);
        drive_op(o);
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        bt = b_taken;
        check_eq("in_ready_idle", in_ready, 1);
        check_eq("b_taken", b_taken, model_taken(o));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        busy = 0;
        forever begin
            #1;
            lat++;
            if (out_valid) break;
            if (!in_ready) busy++;
            if (lat >= 100) break;
            @(negedge clk);
        end
        check_eq("latency", lat, exp_lat);
        check_eq("busy_cycles", busy, exp_lat - 1);
        check_eq("result", result, exp_r);
        check_eq("rd", rd, o.rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_result", result, exp_r);
            check_eq("hold_rd", rd, o.rd);
            check_eq("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check_eq("valid_clear", out_valid, 0);
    endtask

    task automatic start_div(input op_t o);
        @(negedge clk);
        drive_op(o);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic flush_test();
        op_t o, f;
        int pulses;
        o = blank_op(); o.md = 1'b1; o.mop = 3'd4; o.r1 = 32'd100; o.r2 = 32'd3; o.rd = 5'd11;
        start_div(o);
        repeat (9) @(negedge clk);
        f = blank_op(); f.bop = 3'd1; f.r1 = 32'd1; f.rd = 5'd9;
        drive_op(f);
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check_eq("flush_in_ready", in_ready, 0);
        check_eq("flush_b_taken", b_taken, 0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("post_flush_ready", in_ready, 1);
        check_eq("post_flush_valid", out_valid, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check_eq("flush_no_pulse", pulses, 0);
    endtask

    task automatic reset_test();
        op_t o;
        o = blank_op(); o.md = 1'b1; o.mop = 3'd5; o.r1 = 32'd1000; o.r2 = 32'd7; o.rd = 5'd3;
        start_div(o);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_rd", rd, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t o;
        logic bt;
        int lat;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_op(blank_op());
        #1 rst_n = 1'b0;
        #2;
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_result", result, 0);
        check_eq("reset_rd", rd, 0);
        check_eq("reset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        o = blank_op(); o.r1 = 32'd5; o.imm = 32'd7; o.sb = 1'b1; o.rd = 5'd1;
        run_op(o, 0, bt, lat);
        check_eq("add_result", result, 32'd12);
        check_eq("add_latency", lat, 1);

        o = blank_op(); o.fs1 = 2'd1; o.mw = 32'h10; o.r2 = 32'h10; o.bop = 3'd2; o.rd = 5'd2;
        run_op(o, 0, bt, lat);
        check_eq("beq_fwd_taken", bt, 1);
        o.fs1 = 2'd0; o.r1 = 32'd0;
        run_op(o, 0, bt, lat);
        check_eq("beq_not_taken", bt, 0);

        o = blank_op(); o.md = 1'b1; o.mop = 3'd4; o.r1 = 32'hFFFF_FFF9; o.r2 = 32'd2;
        o.rd = 5'd4;
        run_op(o, 0, bt, lat);
        check_eq("div_neg_result", result, 32'hFFFF_FFFD);
        check_eq("div_latency", lat, 33);
        o.mop = 3'd6; o.rd = 5'd5;
        run_op(o, 3, bt, lat);
        check_eq("rem_neg_result", result, 32'hFFFF_FFFF);

        reset_test();

        o = blank_op(); o.md = 1'b1; o.mop = 3'd5; o.r1 = 32'd1234; o.r2 = 32'd0; o.rd = 5'd6;
        run_op(o, 0, bt, lat);
        check_eq("divu_zero_result", result, 32'hFFFF_FFFF);
        check_eq("divu_zero_latency", lat, 1);
        o.mop = 3'd4; o.r1 = 32'h8000_0000; o.r2 = 32'hFFFF_FFFF; o.rd = 5'd7;
        run_op(o, 0, bt, lat);
        check_eq("div_ovf_result", result, 32'h8000_0000);
        check_eq("div_ovf_latency", lat, 1);

        flush_test();

        for (int n = 0; n < 80; n++) begin
            o.fs1 = 2'($urandom_range(0, 3)); o.fs2 = 2'($urandom_range(0, 3));
            o.sa  = 2'($urandom_range(0, 3)); o.sb  = 1'($urandom_range(0, 1));
            o.aop = 4'($urandom_range(0, 9)); o.bop = 3'($urandom_range(0, 7));
            o.md  = 1'($urandom_range(0, 1)); o.mop = 3'($urandom_range(0, 7));
            o.pc  = $urandom; o.r1 = rnd_val(); o.r2 = rnd_val(); o.imm = rnd_val();
            o.mw  = rnd_val(); o.ww = rnd_val(); o.rd = 5'($urandom_range(0, 31));
            run_op(o, $urandom_range(0, 2), bt, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_stage_md.md
EXEC_STAGE_MD -- requirements
Module: exec_stage_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  kill in-flight and accepted op.
REQ-006 SHALL have port in_valid  input  1  decode stage presents an op.
REQ-007 SHALL have port in_ready  output  1  stage can accept op this cycle.
REQ-008 SHALL have port pc  input  XLEN  instruction address.
REQ-009 SHALL have port rrd1 / rrd2  input  XLEN each  register-file operands.
REQ-010 SHALL have port imm  input  XLEN  immediate.
REQ-011 SHALL have port fwd_sel1 / fwd_sel2  input  2 each  00 rrdN, 01 m_regwd, 10 w_regwd, 11 rrdN.
REQ-012 SHALL have port m_regwd / w_regwd  input  XLEN each  forwarded MEM/WB results.
REQ-013 SHALL have port alu_srca  input  2  00 fwd op1, 01 zero, 10 pc, 11 zero.
REQ-014 SHALL have port alu_srcb  input  1  0 fwd op2, 1 imm.
REQ-015 SHALL have port alu_op  input  4  ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND.
REQ-016 SHALL have port bj_op  input  3  NONE,JUMP,BEQ,BNE,BLT,BGE,BLTU,BGEU.
REQ-017 SHALL have port md_en / md_op  input  1 / 3  mul-div select; MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU.
REQ-018 SHALL have port rd_in  input  RA_W  destination register.
REQ-019 SHALL have port out_valid / out_ready  output 1 / input 1  result handshake to MEM.
REQ-020 SHALL have port result / rd  output  XLEN / RA_W  registered result and destination.
REQ-021 SHALL have port b_taken  output  1  combinational branch/jump decision.

Function
REQ-022 SHALL accept an op when in_valid && in_ready; in_ready = IDLE && (!out_valid || out_ready) && !flush.
REQ-023 SHALL compute srca/srcb from forwarded operands per REQ-011/013/014; forwarding also feeds branch compare and mul/div.
REQ-024 SHALL drive b_taken combinationally = in_valid && in_ready && condition(bj_op, srca, srcb); JUMP always taken; NONE never.
REQ-025 SHALL, for md_en=0 or MUL* ops, register result, rd, out_valid=1 on the accepting edge (latency 1).
REQ-026 SHALL compute MUL* from full 2*XLEN signed/unsigned product; MUL low half, others high half.
REQ-027 SHALL run DIV* ops through FSM IDLE -> BUSY -> IDLE, radix-2 restoring, one quotient bit per cycle, XLEN BUSY cycles; result registered on the final BUSY edge (latency XLEN+1).
REQ-028 SHALL operate DIV/REM on magnitudes, negate quotient if operand signs differ, remainder takes dividend sign.
REQ-029 SHALL handle divisor 0 in 1 cycle without BUSY: quotient all-ones, remainder = dividend.
REQ-030 SHALL handle signed overflow (dividend = -2^(XLEN-1), divisor = -1) in 1 cycle: quotient = dividend, remainder 0.
REQ-031 SHALL hold result, rd, out_valid stable while out_valid && !out_ready; clear out_valid on out_ready without a new op.
REQ-032 SHALL, on flush, return FSM to IDLE and clear out_valid on the next edge; a flush-cycle op is not accepted.
REQ-033 SHALL compute shifts using srcb[log2(XLEN)-1:0] only; all arithmetic wraps modulo 2^XLEN.

Reset
REQ-034 SHALL on rst_n=0 immediately force FSM IDLE, out_valid 0, result 0, rd 0, divider registers 0, independent of clk.

Verification
REQ-035 SHALL cover: ADD, rrd1=5, imm=7, alu_srcb=1 -> result=12, out_valid next edge.
REQ-036 SHALL cover: fwd_sel1=01, m_regwd=0x10, rrd2=0x10, BEQ -> b_taken=1; fwd_sel1=00, rrd1=0 -> b_taken=0.
REQ-037 SHALL cover: DIV -7/2, XLEN=32 -> in_ready low 32 cycles, result 0xFFFFFFFD on cycle 33; REM -> 0xFFFFFFFF.
REQ-038 SHALL cover: DIVU x/0 -> result 0xFFFFFFFF latency 1; DIV 0x80000000/-1 -> 0x80000000.
REQ-039 SHALL cover: flush at BUSY cycle 10 -> IDLE and in_ready high next cycle, no out_valid pulse.
REQ-040 SHALL cover: out_ready=0 for 3 cycles after result -> result/rd stable, in_ready 0; rst_n low mid-BUSY -> outputs 0 at once.
